// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage between program_counter and decode. Takes one pc at a time,
// issues a single word read to instruction memory, captures the response and
// offers {instruction, instruction_pc, fetch_error} to decode. A misaligned pc
// or a memory that fails to answer within TIMEOUT_CYCLES produces NOP_INSTR
// with fetch_error set. Flush discards whatever fetch is in progress; a request
// already accepted by memory is drained so its response is never mistaken for
// a later fetch.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   pc, pc_valid        next instruction address from program_counter
//   pc_ready            fetch accepts pc this cycle
//   flush               discard current / in-flight fetch (branch redirect)
//   mem_req_valid       memory read request valid
//   mem_req_ready       memory accepts request
//   mem_req_addr        word address of the request
//   mem_resp_valid      read data valid, one cycle per accepted request
//   mem_resp_data       read data
//   instruction         fetched instruction (NOP_INSTR on error)
//   instruction_pc      pc of instruction
//   instruction_valid   instruction / instruction_pc / fetch_error valid
//   instruction_ready   decode consumes instruction
//   fetch_error         misaligned pc or memory timeout
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic        fetch_error
);

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WAIT_RESP,
    HOLD,
    DRAIN
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_d;
  logic [7:0] counter;

  logic accept;
  logic misaligned;
  logic timeout;

  // Handshake outputs are pure state decodes so reset clears them instantly.
  assign mem_req_valid     = (state == REQUEST);
  assign instruction_valid = (state == HOLD);
  assign pc_ready          = !flush &&
                             ((state == IDLE) || (state == HOLD && instruction_ready));

  assign accept     = pc_valid && pc_ready;
  assign misaligned = (pc[1:0] != 2'b00);
  // DRAIN inherits the counter from WAIT_RESP, which may already be one past
  // the limit if the flush landed on the timeout cycle, hence >= not ==.
  assign timeout    = (counter >= TIMEOUT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    state_d = state;
    unique case (state)
      IDLE: begin
        if (accept) state_d = misaligned ? HOLD : REQUEST;
      end
      REQUEST: begin
        if (flush)              state_d = mem_req_ready ? DRAIN : IDLE;
        else if (mem_req_ready) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        // A response arriving with the flush is consumed on the spot.
        if (flush)               state_d = mem_resp_valid ? IDLE : DRAIN;
        else if (mem_resp_valid) state_d = HOLD;
        else if (timeout)        state_d = HOLD;
      end
      HOLD: begin
        if (flush)                  state_d = IDLE;
        else if (instruction_ready) state_d = accept ? (misaligned ? HOLD : REQUEST) : IDLE;
      end
      DRAIN: begin
        if (mem_resp_valid || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      instruction    <= '0;
      instruction_pc <= '0;
      mem_req_addr   <= '0;
      fetch_error    <= 1'b0;
      counter        <= '0;
    end else begin
      state <= state_d;

      // pc_ready already excludes flush and busy states, so accept is only
      // ever true in IDLE or in a consuming HOLD.
      if (accept) begin
        instruction_pc <= pc;
        if (misaligned) begin
          instruction <= NOP_INSTR;
          fetch_error <= 1'b1;
        end else begin
          mem_req_addr <= pc;
          fetch_error  <= 1'b0;
        end
      end

      unique case (state)
        REQUEST: begin
          if (mem_req_ready) counter <= '0;
        end
        WAIT_RESP: begin
          counter <= counter + 8'd1;
          if (!flush) begin
            if (mem_resp_valid) begin
              instruction <= mem_resp_data;
            end else if (timeout) begin
              instruction <= NOP_INSTR;
              fetch_error <= 1'b1;
            end
          end
        end
        DRAIN: begin
          counter <= counter + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. A per-cycle vector table covers the
// zero-wait fetch, back-to-back fetches with decode backpressure, a misaligned
// pc and the flush cases in IDLE/REQUEST/DRAIN/HOLD. Hand-written sequences
// cover the timeout, a flush while waiting for the response, and asynchronous
// reset in the middle of a fetch.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam logic [31:0] NOP            = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;
  logic        instruction_valid;
  logic        instruction_ready;
  logic        fetch_error;

  instruction_fetch #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .NOP_INSTR     (NOP)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .pc               (pc),
    .pc_valid         (pc_valid),
    .pc_ready         (pc_ready),
    .flush            (flush),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_addr     (mem_req_addr),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_data    (mem_resp_data),
    .instruction      (instruction),
    .instruction_pc   (instruction_pc),
    .instruction_valid(instruction_valid),
    .instruction_ready(instruction_ready),
    .fetch_error      (fetch_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic        pv;
    logic        fl;
    logic        mrr;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        e_pr;
    logic        e_mrv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   applied    = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic void add(
    input logic [31:0] p, input logic pv, input logic fl, input logic mrr,
    input logic rv, input logic [31:0] rd, input logic ir,
    input logic pr, input logic mrv, input logic [31:0] addr, input logic iv,
    input logic [31:0] instr, input logic [31:0] ipc, input logic err);
    vec_t v;
    v.pc = p; v.pv = pv; v.fl = fl; v.mrr = mrr; v.rv = rv; v.rd = rd; v.ir = ir;
    v.e_pr = pr; v.e_mrv = mrv; v.e_addr = addr; v.e_iv = iv;
    v.e_instr = instr; v.e_ipc = ipc; v.e_err = err;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic [31:0] p, input logic pv, input logic fl, input logic mrr,
                       input logic rv, input logic [31:0] rd, input logic ir);
    pc = p; pc_valid = pv; flush = fl; mem_req_ready = mrr;
    mem_resp_valid = rv; mem_resp_data = rd; instruction_ready = ir;
  endtask

  localparam logic [31:0] IA = 32'h0010_0093;
  localparam logic [31:0] IB = 32'h0020_0113;
  localparam logic [31:0] IC = 32'h0030_0193;
  localparam logic [31:0] ID = 32'h0040_0213;
  localparam logic [31:0] IZ = 32'h0050_0093;
  localparam logic [31:0] IE = 32'h0060_0293;

  initial begin
    int cnt;

    //   pc     pv fl mrr rv data ir |  pr mrv addr   iv instr ipc    err
    // Zero-wait fetch of 0x10
    add(32'h10, 1, 0, 0, 0, 0,  0,    1, 0, 32'h0,  0, 0,   32'h0,  0);
    add(32'h0,  0, 0, 1, 0, 0,  0,    0, 1, 32'h10, 0, 0,   32'h10, 0);
    add(32'h0,  0, 0, 0, 1, IZ, 0,    0, 0, 32'h10, 0, 0,   32'h10, 0);
    add(32'h0,  0, 0, 0, 0, 0,  1,    1, 0, 32'h10, 1, IZ,  32'h10, 0);
    add(32'h0,  0, 0, 0, 0, 0,  0,    1, 0, 32'h10, 0, IZ,  32'h10, 0);
    // Back-to-back 0x0, 0x4, 0x8; decode stalls two cycles on 0x4
    add(32'h0,  1, 0, 0, 0, 0,  0,    1, 0, 32'h10, 0, IZ,  32'h10, 0);
    add(32'h0,  0, 0, 1, 0, 0,  0,    0, 1, 32'h0,  0, IZ,  32'h0,  0);
    add(32'h0,  0, 0, 0, 1, IA, 0,    0, 0, 32'h0,  0, IZ,  32'h0,  0);
    add(32'h4,  1, 0, 0, 0, 0,  1,    1, 0, 32'h0,  1, IA,  32'h0,  0);
    add(32'h0,  0, 0, 1, 0, 0,  0,    0, 1, 32'h4,  0, IA,  32'h4,  0);
    add(32'h0,  0, 0, 0, 1, IB, 0,    0, 0, 32'h4,  0, IA,  32'h4,  0);
    add(32'h8,  1, 0, 0, 0, 0,  0,    0, 0, 32'h4,  1, IB,  32'h4,  0);
    add(32'h8,  1, 0, 0, 0, 0,  0,    0, 0, 32'h4,  1, IB,  32'h4,  0);
    add(32'h8,  1, 0, 0, 0, 0,  1,    1, 0, 32'h4,  1, IB,  32'h4,  0);
    add(32'h0,  0, 0, 1, 0, 0,  0,    0, 1, 32'h8,  0, IB,  32'h8,  0);
    add(32'h0,  0, 0, 0, 1, IC, 0,    0, 0, 32'h8,  0, IB,  32'h8,  0);
    add(32'h0,  0, 0, 0, 0, 0,  1,    1, 0, 32'h8,  1, IC,  32'h8,  0);
    // Misaligned pc 0x6: no request, NOP with error
    add(32'h6,  1, 0, 0, 0, 0,  0,    1, 0, 32'h8,  0, IC,  32'h8,  0);
    add(32'h0,  0, 0, 0, 0, 0,  0,    0, 0, 32'h8,  1, NOP, 32'h6,  1);
    add(32'h0,  0, 0, 0, 0, 0,  1,    1, 0, 32'h8,  1, NOP, 32'h6,  1);
    // Flush in IDLE blocks accept; flush in REQUEST before acceptance withdraws
    add(32'h20, 1, 1, 0, 0, 0,  0,    0, 0, 32'h8,  0, NOP, 32'h6,  0);
    add(32'h20, 1, 0, 0, 0, 0,  0,    1, 0, 32'h8,  0, NOP, 32'h6,  0);
    add(32'h0,  0, 0, 0, 0, 0,  0,    0, 1, 32'h20, 0, NOP, 32'h20, 0);
    add(32'h0,  0, 1, 0, 0, 0,  0,    0, 1, 32'h20, 0, NOP, 32'h20, 0);
    // Stray response in IDLE is ignored
    add(32'h0,  0, 0, 0, 1, ID, 0,    1, 0, 32'h20, 0, NOP, 32'h20, 0);
    // Flush on the accepting edge of REQUEST -> DRAIN, response discarded
    add(32'h24, 1, 0, 0, 0, 0,  0,    1, 0, 32'h20, 0, NOP, 32'h20, 0);
    add(32'h0,  0, 1, 1, 0, 0,  0,    0, 1, 32'h24, 0, NOP, 32'h24, 0);
    add(32'h28, 1, 0, 0, 0, 0,  0,    0, 0, 32'h24, 0, NOP, 32'h24, 0);
    add(32'h28, 1, 0, 0, 1, ID, 0,    0, 0, 32'h24, 0, NOP, 32'h24, 0);
    // Normal fetch then flush while held drops the instruction
    add(32'h28, 1, 0, 0, 0, 0,  0,    1, 0, 32'h24, 0, NOP, 32'h24, 0);
    add(32'h0,  0, 0, 1, 0, 0,  0,    0, 1, 32'h28, 0, NOP, 32'h28, 0);
    add(32'h0,  0, 0, 0, 1, ID, 0,    0, 0, 32'h28, 0, NOP, 32'h28, 0);
    add(32'h2c, 1, 1, 0, 0, 0,  1,    0, 0, 32'h28, 1, ID,  32'h28, 0);
    add(32'h0,  0, 0, 0, 0, 0,  0,    1, 0, 32'h28, 0, ID,  32'h28, 0);

    // ---- Reset state ----
    drive(32'h0, 0, 0, 0, 0, 32'h0, 0);
    reset = 1'b1;
    #1;
    check("reset.instruction_valid", 32'(instruction_valid), 32'h0);
    check("reset.mem_req_valid",     32'(mem_req_valid),     32'h0);
    check("reset.pc_ready",          32'(pc_ready),          32'h1);
    check("reset.instruction",       instruction,            32'h0);
    check("reset.instruction_pc",    instruction_pc,         32'h0);
    check("reset.mem_req_addr",      mem_req_addr,           32'h0);
    check("reset.fetch_error",       32'(fetch_error),       32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // ---- Table-driven vectors: drive at negedge, compare 1 time unit later ----
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clock);
      drive(vecs[i].pc, vecs[i].pv, vecs[i].fl, vecs[i].mrr, vecs[i].rv, vecs[i].rd, vecs[i].ir);
      #1;
      check($sformatf("v%0d.pc_ready", i),          32'(pc_ready),          32'(vecs[i].e_pr));
      check($sformatf("v%0d.mem_req_valid", i),     32'(mem_req_valid),     32'(vecs[i].e_mrv));
      check($sformatf("v%0d.mem_req_addr", i),      mem_req_addr,           vecs[i].e_addr);
      check($sformatf("v%0d.instruction_valid", i), 32'(instruction_valid), 32'(vecs[i].e_iv));
      check($sformatf("v%0d.instruction", i),       instruction,            vecs[i].e_instr);
      check($sformatf("v%0d.instruction_pc", i),    instruction_pc,         vecs[i].e_ipc);
      if (vecs[i].e_iv)
        check($sformatf("v%0d.fetch_error", i),     32'(fetch_error),       32'(vecs[i].e_err));
    end

    // ---- Timeout: memory accepts but never answers ----
    @(negedge clock); drive(32'h40, 1, 0, 0, 0, 32'h0, 0);
    @(negedge clock); drive(32'h0,  0, 0, 1, 0, 32'h0, 0);
    #1 check("to.mem_req_valid", 32'(mem_req_valid), 32'h1);
    @(negedge clock); drive(32'h0,  0, 0, 0, 0, 32'h0, 0);
    cnt = 0;
    while (!instruction_valid && cnt < 40) begin
      #1 check("to.no_req_while_waiting", 32'(mem_req_valid), 32'h0);
      cnt++;
      @(negedge clock);
    end
    check("to.wait_cycles",    32'(cnt),         32'(TIMEOUT_CYCLES));
    check("to.instruction",    instruction,      NOP);
    check("to.fetch_error",    32'(fetch_error), 32'h1);
    check("to.instruction_pc", instruction_pc,   32'h40);
    drive(32'h0, 0, 0, 0, 1, 32'hdead_beef, 0);  // late response while held
    @(negedge clock); drive(32'h0, 0, 0, 0, 0, 32'h0, 1);
    #1 check("to.late_ignored", instruction, NOP);
    check("to.still_valid", 32'(instruction_valid), 32'h1);
    @(negedge clock); drive(32'h0, 0, 0, 0, 1, 32'hdead_beef, 0);  // late response in IDLE
    @(negedge clock); drive(32'h0, 0, 0, 0, 0, 32'h0, 0);
    #1 check("to.idle_after", 32'(instruction_valid), 32'h0);
    check("to.idle_instr", instruction, NOP);

    // ---- Flush in WAIT_RESP, response three cycles later, pc_valid held ----
    @(negedge clock); drive(32'h50, 1, 0, 0, 0, 32'h0, 1);
    @(negedge clock); drive(32'h54, 1, 0, 1, 0, 32'h0, 1);   // REQUEST, accepted
    @(negedge clock); drive(32'h54, 1, 1, 0, 0, 32'h0, 1);   // WAIT_RESP, flush
    #1 check("fw.pr_flush", 32'(pc_ready), 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock); drive(32'h54, 1, 0, 0, 0, 32'h0, 1);
      #1 check($sformatf("fw.drain%0d.pc_ready", k), 32'(pc_ready), 32'h0);
      check($sformatf("fw.drain%0d.iv", k), 32'(instruction_valid), 32'h0);
    end
    @(negedge clock); drive(32'h54, 1, 0, 0, 1, 32'hbad0_0bad, 1);
    #1 check("fw.resp.pc_ready", 32'(pc_ready), 32'h1 ^ 32'h1);
    check("fw.resp.iv", 32'(instruction_valid), 32'h0);
    @(negedge clock); drive(32'h54, 1, 0, 0, 0, 32'h0, 1);
    #1 check("fw.idle.pc_ready", 32'(pc_ready), 32'h1);
    check("fw.idle.iv", 32'(instruction_valid), 32'h0);
    @(negedge clock); drive(32'h0, 0, 0, 1, 0, 32'h0, 0);
    #1 check("fw.next.addr", mem_req_addr, 32'h54);
    check("fw.next.mrv", 32'(mem_req_valid), 32'h1);
    @(negedge clock); drive(32'h0, 0, 0, 0, 1, IE, 0);
    @(negedge clock); drive(32'h0, 0, 0, 0, 0, 32'h0, 0);
    #1 check("fw.next.iv",    32'(instruction_valid), 32'h1);
    check("fw.next.instr", instruction,      IE);
    check("fw.next.ipc",   instruction_pc,   32'h54);
    check("fw.next.err",   32'(fetch_error), 32'h0);

    // ---- Asynchronous reset while waiting for a response ----
    @(negedge clock); drive(32'h60, 1, 0, 0, 0, 32'h0, 1);
    @(negedge clock); drive(32'h0,  0, 0, 1, 0, 32'h0, 0);
    @(negedge clock); drive(32'h0,  0, 0, 0, 0, 32'h0, 0);   // in WAIT_RESP
    #1 check("ar.pre.pc_ready", 32'(pc_ready), 32'h0);
    #1 reset = 1'b1;
    #1;   // still mid-cycle, no clock edge since reset rose
    check("ar.iv",    32'(instruction_valid), 32'h0);
    check("ar.mrv",   32'(mem_req_valid),     32'h0);
    check("ar.pr",    32'(pc_ready),          32'h1);
    check("ar.instr", instruction,            32'h0);
    check("ar.ipc",   instruction_pc,         32'h0);
    check("ar.addr",  mem_req_addr,           32'h0);
    check("ar.err",   32'(fetch_error),       32'h0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    check("ar.post.pr",  32'(pc_ready),          32'h1);
    check("ar.post.mrv", 32'(mem_req_valid),     32'h0);
    check("ar.post.iv",  32'(instruction_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
